// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with 16x oversampling and a receive FIFO.
//
// Ports:
//   clk      single clock, all state on rising edge
//   rstn     synchronous active-low reset
//   rx       serial line, idle high, asynchronous to clk
//   divisor  clk cycles per oversample tick; 0 behaves as 1
//   pop      consume FIFO head
//   flush    empty the FIFO (receiver FSM unaffected)
//   clr_err  clear sticky oe/fe/bi (a same-cycle set wins)
//   rdata    FIFO head byte, 0x00 when empty
//   dr       FIFO non-empty
//   count    FIFO occupancy
//   oe/fe/bi sticky overrun / framing error / break
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        rx,
  input  logic [15:0]                 divisor,
  input  logic                        pop,
  input  logic                        flush,
  input  logic                        clr_err,
  output logic [7:0]                  rdata,
  output logic                        dr,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        oe,
  output logic                        fe,
  output logic                        bi
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  // synchronizer
  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;

  // receiver
  state_t      state_q, state_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [15:0] div_lim_q, div_lim_d;
  logic [15:0] div_lim_new;
  logic [3:0]  samp_q, samp_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tick;
  logic        push;
  logic        fe_set;
  logic        bi_set;

  // fifo
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;
  logic          full;
  logic          ovr;

  // sticky flags
  logic oe_q, oe_d;
  logic fe_q, fe_d;
  logic bi_q, bi_d;

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
  end

  // Receiver FSM: next state, oversampling counters, shift register.
  // The tick limit is latched only on reload so a divisor change can never
  // leave the counter above its compare value.
  always_comb begin
    div_lim_new = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    tick        = (tick_cnt_q == div_lim_q);

    state_d    = state_q;
    tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
    div_lim_d  = tick ? div_lim_new : div_lim_q;
    samp_d     = samp_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push       = 1'b0;
    fe_set     = 1'b0;
    bi_set     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Entry to IDLE always happens with rx_s high (reset, false start,
        // good stop, end of break), so a low level here is a falling edge.
        if (!rx_s_q) begin
          tick_cnt_d = 16'd0;
          div_lim_d  = div_lim_new;
          samp_d     = 4'd0;
          bit_idx_d  = 3'd0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (samp_q == 4'd7) begin
            samp_d  = 4'd0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (samp_q == 4'd15) begin
            samp_d    = 4'd0;
            shift_d   = {rx_s_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = S_STOP;
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (samp_q == 4'd15) begin
            samp_d = 4'd0;
            push   = 1'b1;
            if (rx_s_q) begin
              state_d = S_IDLE;
            end else begin
              fe_set  = 1'b1;
              bi_set  = (shift_q == 8'h00);
              state_d = S_BRK_WAIT;
            end
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
      end
      S_BRK_WAIT: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control; flush overrides push and pop.
  always_comb begin
    full    = (count_q == CW'(FIFO_DEPTH));
    pop_ok  = pop && (count_q != '0);
    push_ok = push && (!full || pop_ok);
    ovr     = push && full && !pop_ok;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    oe_d = (oe_q & ~clr_err) | (ovr & ~flush);
    fe_d = (fe_q & ~clr_err) | fe_set;
    bi_d = (bi_q & ~clr_err) | bi_set;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      tick_cnt_q <= 16'd0;
      div_lim_q  <= 16'd0;
      samp_q     <= 4'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      oe_q       <= 1'b0;
      fe_q       <= 1'b0;
      bi_q       <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      div_lim_q  <= div_lim_d;
      samp_q     <= samp_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      oe_q       <= oe_d;
      fe_q       <= fe_d;
      bi_q       <= bi_d;
    end
  end

  // Storage needs no reset: rdata is gated by occupancy.
  always_ff @(posedge clk) begin
    if (rstn && push_ok && !flush) mem[wr_ptr_q] <= shift_q;
  end

  assign rdata = (count_q != '0) ? mem[rd_ptr_q] : 8'h00;
  assign dr    = (count_q != '0);
  assign count = count_q;
  assign oe    = oe_q;
  assign fe    = fe_q;
  assign bi    = bi_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx;
  logic [15:0] divisor;
  logic        pop;
  logic        flush;
  logic        clr_err;
  logic [7:0]  rdata;
  logic        dr;
  logic [4:0]  count;
  logic        oe, fe, bi;

  uart_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .divisor(divisor), .pop(pop),
    .flush(flush), .clr_err(clr_err), .rdata(rdata), .dr(dr),
    .count(count), .oe(oe), .fe(fe), .bi(bi)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: byte queue plus sticky flags, updated per whole frame.
  logic [7:0] q[$];
  logic m_oe = 1'b0, m_fe = 1'b0, m_bi = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    check({tag, ".dr"},    32'(dr),    32'(q.size() != 0));
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".rdata"}, 32'(rdata), 32'(head));
    check({tag, ".oe"},    32'(oe),    32'(m_oe));
    check({tag, ".fe"},    32'(fe),    32'(m_fe));
    check({tag, ".bi"},    32'(bi),    32'(m_bi));
  endtask

  function automatic void model_push(input logic [7:0] b, input logic stop_bit);
    if (q.size() == DEPTH) m_oe = 1'b1;
    else q.push_back(b);
    if (!stop_bit) begin
      m_fe = 1'b1;
      if (b == 8'h00) m_bi = 1'b1;
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int d);
    logic [9:0] f;
    int bl;
    bl = 16 * ((d == 0) ? 1 : d);
    divisor = 16'(d);
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      cyc(bl);
    end
    rx = 1'b1;
    cyc(8);
    model_push(b, stop_bit);
  endtask

  // Cycle-exact frame at divisor 1. pop_cycle>0 pulses pop during the cycle
  // ending at that edge; chk verifies the 155-cycle push latency.
  task automatic send_exact(input logic [7:0] b, input int pop_cycle, input bit chk);
    logic [9:0] f;
    divisor = 16'd1;
    f = {1'b1, b, 1'b0};
    rx = 1'b0;
    for (int n = 1; n <= 160; n++) begin
      @(posedge clk);
      #1;
      if (n == pop_cycle) pop = 1'b0;
      if (n == pop_cycle - 1) pop = 1'b1;
      if (chk && n == 154) check("lat154.dr", 32'(dr), 32'd0);
      if (chk && n == 155) begin
        check("lat155.dr",    32'(dr),    32'd1);
        check("lat155.rdata", 32'(rdata), 32'(b));
        check("lat155.count", 32'(count), 32'd1);
      end
      if (n < 160) rx = f[n / 16];
      else rx = 1'b1;
    end
    cyc(8);
    if (pop_cycle > 0 && q.size() != 0) void'(q.pop_front());
    model_push(b, 1'b1);
  endtask

  task automatic do_pop();
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic do_clr();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    m_oe = 1'b0; m_fe = 1'b0; m_bi = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int d;
    logic sb;

    rstn = 1'b0; rx = 1'b1; divisor = 16'd1;
    pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    cyc(3);
    check_all("reset");
    rstn = 1'b1;
    cyc(4);

    // exact latency of 0x55, then pop
    send_exact(8'h55, 0, 1'b1);
    check_all("x55");
    do_pop();
    check_all("x55_pop");

    // pop on empty is ignored
    do_pop();
    check_all("pop_empty");

    // false start glitch, then a good byte
    rx = 1'b0;
    cyc(4);
    rx = 1'b1;
    cyc(40);
    check_all("glitch");
    send_frame(8'hA3, 1'b1, 1);
    check_all("xA3");
    do_pop();

    // framing error
    send_frame(8'hA5, 1'b0, 1);
    check_all("fe_A5");
    do_clr();
    check_all("fe_clr");
    do_pop();

    // break: 20 bit times low
    rx = 1'b0;
    cyc(320);
    rx = 1'b1;
    cyc(8);
    model_push(8'h00, 1'b0);
    check_all("break");
    do_clr();
    do_pop();
    send_frame(8'h3C, 1'b1, 1);
    check_all("after_brk");
    do_pop();

    // overflow: 17 bytes into a 16-entry FIFO
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1);
    check_all("ovf");
    for (int i = 0; i < 16; i++) begin
      check("ovf_pop", 32'(rdata), 32'(i));
      do_pop();
    end
    check_all("ovf_empty");

    // refill, then push and pop in the same cycle while full
    for (int i = 0; i < 16; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1);
    do_clr();
    check_all("full_again");
    send_exact(8'h99, 155, 1'b0);
    check_all("push_pop_full");
    while (q.size() != 0) begin
      check("drain", 32'(rdata), 32'(q[0]));
      do_pop();
    end
    check_all("drained");

    // reset during bit 4, then 0x7E
    send_frame(8'h11, 1'b1, 1);
    divisor = 16'd1;
    rx = 1'b0;
    cyc(16);
    rx = 1'b1; cyc(16); rx = 1'b0; cyc(16); rx = 1'b1; cyc(16); rx = 1'b0; cyc(16);
    rx = 1'b1;
    cyc(8);
    rstn = 1'b0;
    cyc(3);
    rx = 1'b1;
    rstn = 1'b1;
    q.delete();
    m_oe = 1'b0; m_fe = 1'b0; m_bi = 1'b0;
    cyc(4);
    send_frame(8'h7E, 1'b1, 1);
    check_all("rst_mid");
    do_pop();

    // randomized frames over divisors 0..3
    for (int i = 0; i < 12; i++) begin
      b  = 8'($urandom_range(0, 255));
      d  = $urandom_range(0, 3);
      sb = ($urandom_range(0, 4) != 0);
      send_frame(b, sb, d);
      check_all("rand");
      if ($urandom_range(0, 1) == 1) do_pop();
      if (m_fe) do_clr();
    end
    do_flush();
    check_all("flush");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
